// File: rtl/profile_ctrl_ci_if.sv
// profile_ctrl_ci_if: CPU custom-instruction port bundle
// master = CPU side, slave = CI controller side
interface profile_ctrl_ci_if;
   logic        start;
   logic [7:0]  ciN;
   logic [31:0] valueA;
   logic [31:0] valueB;
   logic        stall;
   logic        busIdle;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, ciN, valueA, valueB,
      output stall, busIdle,
      input  done, result
   );

   modport slave (
      input  start, ciN, valueA, valueB,
      input  stall, busIdle,
      output done, result
   );
endinterface

// File: rtl/profile_ctrl_ci.sv
// profile_ctrl_ci: CI controller for four profiling counters
// Optional sticky overflow flags: PROFILE_CTRL_OVERFLOW_EN
module profile_ctrl_ci #(
   parameter logic [7:0] customId      = 8'h00,
   parameter int         COUNTER_WIDTH = 32
) (
   input logic             clock,
   input logic             reset,
   profile_ctrl_ci_if.slave bus
);

   logic [COUNTER_WIDTH-1:0] cnt [4];
   logic [3:0]  en;
   logic [3:0]  en_nxt;
   logic [3:0]  ovf;
   logic        accept;
   logic [3:0]  set_en;
   logic [3:0]  clr_en;
   logic [3:0]  clr_cnt;
   logic [3:0]  cond;
   logic [3:0]  inc;
   logic [31:0] rd;
   logic        unused;

   assign unused = ^{bus.valueA[31:3], bus.valueB[31:12]};

   assign accept  = bus.start && (bus.ciN == customId);
   assign set_en  = accept ? bus.valueB[3:0]  : 4'b0;
   assign clr_en  = accept ? bus.valueB[7:4]  : 4'b0;
   assign clr_cnt = accept ? bus.valueB[11:8] : 4'b0;
   assign en_nxt  = (en | set_en) & ~clr_en;
   assign cond    = {~bus.stall, bus.busIdle, bus.stall, 1'b1};

   // Increment qualifiers; clears at this edge suppress counting
   always_comb begin
      inc = en & ~clr_en & ~clr_cnt & cond;
   end

   // Read mux on pre-edge state
   always_comb begin
      rd = '0;
      if (bus.valueA[2]) begin
         rd = {24'b0, ovf, en};
      end else begin
         rd[COUNTER_WIDTH-1:0] = cnt[bus.valueA[1:0]];
      end
   end

   // Handshake, enables and counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.done   <= 1'b0;
         bus.result <= '0;
         en         <= 4'b0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         bus.done   <= accept;
         bus.result <= accept ? rd : 32'b0;
         en         <= en_nxt;
         for (int i = 0; i < 4; i++) begin
            if (clr_cnt[i]) begin
               cnt[i] <= '0;
            end else if (inc[i]) begin
               cnt[i] <= cnt[i] + COUNTER_WIDTH'(1);
            end
         end
      end
   end

`ifdef PROFILE_CTRL_OVERFLOW_EN
   // Sticky wrap flags; a counter clear takes priority over a wrap
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf <= 4'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (clr_cnt[i]) begin
               ovf[i] <= 1'b0;
            end else if (inc[i] && (&cnt[i])) begin
               ovf[i] <= 1'b1;
            end
         end
      end
   end
`else
   assign ovf = 4'b0;
`endif

endmodule

// File: tb/tb_profile_ctrl_ci.sv
// tb_profile_ctrl_ci: directed checks for profile_ctrl_ci
// unit 0: 32-bit counters, unit 1: 4-bit counters
module tb_profile_ctrl_ci;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fails  = 0;

   profile_ctrl_ci_if bus0 ();
   profile_ctrl_ci_if bus1 ();

   profile_ctrl_ci #(
      .customId      (8'h00),
      .COUNTER_WIDTH (32)
   ) dut0 (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus0)
   );

   profile_ctrl_ci #(
      .customId      (8'h07),
      .COUNTER_WIDTH (4)
   ) dut1 (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic drive(input int u, input logic s,
                        input logic [7:0] id,
                        input logic [31:0] a,
                        input logic [31:0] b);
      if (u == 0) begin
         bus0.start  = s;
         bus0.ciN    = id;
         bus0.valueA = a;
         bus0.valueB = b;
      end else begin
         bus1.start  = s;
         bus1.ciN    = id;
         bus1.valueA = a;
         bus1.valueB = b;
      end
   endtask

   task automatic cmd(input int u, input logic [7:0] id,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] exp,
                      input string tag);
      drive(u, 1'b1, id, a, b);
      @(posedge clk);
      #1;
      check({tag, "_done"}, u == 0 ? 32'(bus0.done) : 32'(bus1.done), 1);
      check({tag, "_res"}, u == 0 ? bus0.result : bus1.result, exp);
      drive(u, 1'b0, id, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      check({tag, "_done0"}, u == 0 ? 32'(bus0.done) : 32'(bus1.done), 0);
      check({tag, "_res0"}, u == 0 ? bus0.result : bus1.result, 0);
   endtask

   initial begin
      logic [31:0] st1;
`ifdef PROFILE_CTRL_OVERFLOW_EN
      st1 = 32'h11;
`else
      st1 = 32'h01;
`endif
      rst_n        = 1'b0;
      drive(0, 1'b0, 8'h00, 32'h0, 32'h0);
      drive(1, 1'b0, 8'h07, 32'h0, 32'h0);
      bus0.stall   = 1'b0;
      bus0.busIdle = 1'b0;
      bus1.stall   = 1'b0;
      bus1.busIdle = 1'b0;
      #12;
      check("rst_done0", 32'(bus0.done), 0);
      check("rst_res0", bus0.result, 0);
      check("rst_done1", 32'(bus1.done), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      cmd(1, 8'h07, 32'h0, 32'h001, 32'h0, "u1_en");
      repeat (16) @(posedge clk);
      #1;
      cmd(1, 8'h07, 32'h0, 32'h0, 32'h1, "u1_wrap");
      cmd(1, 8'h07, 32'h4, 32'h0, st1, "u1_stat");
      cmd(1, 8'h07, 32'h4, 32'h100, st1, "u1_clrovf");
      cmd(1, 8'h07, 32'h4, 32'h0, 32'h1, "u1_stat2");

      cmd(0, 8'h00, 32'h4, 32'h0, 32'h0, "stat_rst");
      cmd(0, 8'h00, 32'h0, 32'h00F, 32'h0, "en_all");
      cmd(0, 8'h00, 32'h1, 32'h0, 32'h0, "cnt1_pre");
      bus0.stall = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      bus0.stall = 1'b0;
      cmd(0, 8'h00, 32'h1, 32'h0, 32'd10, "cnt1_post");
      cmd(0, 8'h00, 32'h2, 32'h0, 32'd0, "cnt2");
      cmd(0, 8'h00, 32'hFFFF_FFF8, 32'h0, 32'd17, "cnt0");
      cmd(0, 8'h00, 32'h3, 32'h0, 32'd9, "cnt3");
      cmd(0, 8'h00, 32'h0, 32'h100, 32'd21, "rdclr");
      cmd(0, 8'h00, 32'h0, 32'h0, 32'd1, "rdclr_2nd");
      cmd(0, 8'h00, 32'h4, 32'h011, 32'h0F, "setclr");
      cmd(0, 8'h00, 32'h4, 32'h0, 32'h0E, "stat_off");
      cmd(0, 8'h00, 32'h0, 32'h0, 32'd3, "frozen");

      drive(0, 1'b1, 8'h07, 32'h4, 32'h0F0);
      @(posedge clk);
      #1;
      check("badid_done", 32'(bus0.done), 0);
      check("badid_res", bus0.result, 0);
      @(posedge clk);
      #1;
      check("badid_done2", 32'(bus0.done), 0);
      drive(0, 1'b0, 8'h00, 32'h0, 32'h0);
      cmd(0, 8'h00, 32'h4, 32'h0, 32'h0E, "badid_stat");
      cmd(0, 8'h00, 32'h0, 32'h0, 32'd3, "badid_cnt0");

      drive(0, 1'b1, 8'h00, 32'h3, 32'h0);
      @(posedge clk);
      #1;
      check("arst_pre", 32'(bus0.done), 1);
      rst_n = 1'b0;
      #1;
      check("arst_done", 32'(bus0.done), 0);
      check("arst_res", bus0.result, 0);
      drive(0, 1'b0, 8'h00, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cmd(0, 8'h00, 32'h4, 32'h0, 32'h0, "post_stat");
      cmd(0, 8'h00, 32'h0, 32'h0, 32'h0, "post_c0");
      cmd(0, 8'h00, 32'h1, 32'h0, 32'h0, "post_c1");
      cmd(0, 8'h00, 32'h2, 32'h0, 32'h0, "post_c2");
      cmd(0, 8'h00, 32'h3, 32'h0, 32'h0, "post_c3");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
